// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: same-cycle hits and single-word
// fills from memory on a miss. It also keeps saturating hit and miss counters.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        o_dbg_state
);

  // Handshake: the fill data on iload is taken in a FETCH cycle where iwait == 0.
  // Data is taken at the rising edge that ends that cycle, unless halt is also high.
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];
  logic [31:0]        r_miss_addr;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_lookup;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill;
  logic               w_unused;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag = r_miss_addr[31:IDX_W+2];
  assign w_unused   = ^{imemaddr[1:0], r_miss_addr[1:0]};

  assign w_lookup = imemREN && !halt && (r_state == IDLE);
  assign w_hit    = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = w_lookup && !w_hit;
  // halt takes priority over a completing fill, so an aborted fetch never writes.
  assign w_fill   = (r_state == FETCH) && !halt && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_next = FETCH;
      FETCH:   if (halt || !iwait) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ihit        = w_hit;
    imemload    = w_hit ? r_data[w_idx] : 32'h0;
    iREN        = (r_state == FETCH);
    iaddr       = r_miss_addr;
    o_dbg_state = r_state;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid     <= '0;
      r_miss_addr <= 32'h0;
      r_hit_cnt   <= 32'h0;
      r_miss_cnt  <= 32'h0;
    end else begin
      if (w_miss) begin
        r_miss_addr <= {imemaddr[31:2], 2'b00};
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
